instr_fetch_queue: RTL

Instruction fetch stage with prefetch buffering for the pipelined MIPS core. It owns the fetch PC, issues word reads to instruction memory over a request/acknowledge handshake that tolerates variable latency, and buffers returned words in a small FIFO. It drives the IF/ID pipeline register (instrD, pcplus4D) consumed by the decode stage, honouring the hazard unit's stallD and the controller's pcsrcD redirect.

---
 rtl/instr_fetch_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues imem reads, buffers words in a prefetch FIFO
// and drives the IF/ID register. Optional define FETCH_BYPASS_EN writes responses straight to IF/ID.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} fetchState_e;

  fetchState_e     stateQ;
  logic [31:0]     fetchPC;
  logic [CntW-1:0] countQ, countNext;
  logic [PtrW-1:0] wrPtr, rdPtr;
  logic [63:0]     fifoMem [DEPTH];
  logic [63:0]     fifoHead;
  logic [31:0]     fetchPCPlus4, redirectPC;
  logic            fifoEmpty, flush, ack, bypass, enq, deq, slotFree;
  logic            unusedBits;

  assign fifoEmpty    = (countQ == '0);
  assign flush        = pcsrcD & ~stallD;
  assign ack          = (stateQ == StWait) & imem_ack;
  assign fetchPCPlus4 = fetchPC + 32'd4;
  assign redirectPC   = {pcbranchD[31:2], 2'b00};
  assign unusedBits   = ^pcbranchD[1:0];

`ifdef FETCH_BYPASS_EN
  assign bypass = ack & fifoEmpty & ~stallD & ~pcsrcD;
`else
  assign bypass = 1'b0;
`endif

  // A word arriving during a flush is dropped; a bypassed word goes straight to IF/ID.
  assign enq      = ack & ~flush & ~bypass;
  assign deq      = ~stallD & ~pcsrcD & ~fifoEmpty;
  assign fifoHead = fifoMem[rdPtr];

  always_comb begin
    countNext = countQ;
    if (flush) begin
      countNext = '0;
    end else if (enq && !deq) begin
      countNext = countQ + CntW'(1);
    end else if (deq && !enq) begin
      countNext = countQ - CntW'(1);
    end
  end

  assign slotFree = (countNext < DepthCnt);

  assign imem_req  = (stateQ != StIdle);
  assign imem_addr = fetchPC;

  // Fetch FSM and PC; only one request is ever outstanding, so the FIFO cannot overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= StIdle;
      fetchPC <= RESET_PC;
    end else begin
      if (flush) begin
        fetchPC <= redirectPC;
      end else if (ack) begin
        fetchPC <= fetchPCPlus4;
      end
      unique case (stateQ)
        StIdle: begin
          if (!flush && slotFree) stateQ <= StWait;
        end
        StWait: begin
          if (flush) begin
            stateQ <= imem_ack ? StIdle : StDiscard;
          end else if (imem_ack && !slotFree) begin
            stateQ <= StIdle;
          end
        end
        StDiscard: begin
          if (imem_ack) stateQ <= StIdle;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      countQ <= countNext;
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (enq) wrPtr <= wrPtr + PtrW'(1);
        if (deq) rdPtr <= rdPtr + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifoMem[wrPtr] <= {imem_rdata, fetchPCPlus4};
  end

  // IF/ID register: holds under stall, otherwise cleared unless a word is available.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrD   <= '0;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else if (!stallD) begin
      if (pcsrcD) begin
        instrD   <= '0;
        pcplus4D <= '0;
        validD   <= 1'b0;
      end else if (bypass) begin
        instrD   <= imem_rdata;
        pcplus4D <= fetchPCPlus4;
        validD   <= 1'b1;
      end else if (!fifoEmpty) begin
        instrD   <= fifoHead[63:32];
        pcplus4D <= fifoHead[31:0];
        validD   <= 1'b1;
      end else begin
        instrD   <= '0;
        pcplus4D <= '0;
        validD   <= 1'b0;
      end
    end
  end

endmodule
